// File: rtl/pc_sequencer.sv
// Program counter sequencer fed by the branch-target lookup table.
// Runs one program per start request (IDLE -> RUN -> DONE) and counts RUN cycles.
module pc_sequencer #(
   parameter int D  = 12,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          halt,
   input  logic          branch_en,
   input  logic          taken,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          busy,
   output logic          done,
   output logic          bad_target,
   output logic [CW-1:0] cyc_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_p1, state_nxt;
   logic [D-1:0]  pc_p1, pc_nxt;
   logic [CW-1:0] cyc_p1, cyc_nxt;
   logic          bad_p1, bad_nxt;
   logic          redirect;

   // Plain increment wraps modulo 2^D with no flag.
   function automatic logic [D-1:0] pc_inc(input logic [D-1:0] pc);
      return pc + D'(1);
   endfunction

   // Cycle counter sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] cyc_sat(input logic [CW-1:0] c);
      return (c == {CW{1'b1}}) ? c : c + CW'(1);
   endfunction

   // A zero target is the lookup table's invalid-index default, never a real destination.
   assign redirect = branch_en && taken && (target != '0);

   always_comb begin
      state_nxt = state_p1;
      pc_nxt    = pc_p1;
      cyc_nxt   = cyc_p1;
      bad_nxt   = bad_p1;
      case (state_p1)
         IDLE: begin
            pc_nxt = '0;
            if (start) begin
               state_nxt = RUN;
               cyc_nxt   = '0;
               bad_nxt   = 1'b0;
            end
         end
         RUN: begin
            if (start) begin
               pc_nxt  = '0;
               cyc_nxt = '0;
               bad_nxt = 1'b0;
            end else if (halt) begin
               state_nxt = DONE;
               cyc_nxt   = cyc_sat(cyc_p1);
            end else if (stall) begin
               cyc_nxt = cyc_sat(cyc_p1);
            end else begin
               cyc_nxt = cyc_sat(cyc_p1);
               if (redirect) begin
                  pc_nxt = target;
               end else begin
                  pc_nxt = pc_inc(pc_p1);
                  if (branch_en && taken) begin
                     bad_nxt = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
               cyc_nxt   = '0;
               bad_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            pc_nxt    = '0;
            cyc_nxt   = '0;
            bad_nxt   = 1'b0;
         end
      endcase
   end

   // Stage p1: architectural state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_p1 <= IDLE;
         pc_p1    <= '0;
         cyc_p1   <= '0;
         bad_p1   <= 1'b0;
      end else begin
         state_p1 <= state_nxt;
         pc_p1    <= pc_nxt;
         cyc_p1   <= cyc_nxt;
         bad_p1   <= bad_nxt;
      end
   end

   assign prog_ctr   = pc_p1;
   assign cyc_count  = cyc_p1;
   assign bad_target = bad_p1;
   assign busy       = (state_p1 == RUN);
   assign done       = (state_p1 == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a cycle-level reference model; a CW=4 copy exercises saturation.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, stall = 1'b0, halt = 1'b0, branch_en = 1'b0, taken = 1'b0;
   logic [11:0] target = '0;
   logic [11:0] prog_ctr, prog_ctr4;
   logic        busy, done, bad_target, busy4, done4, bad_target4;
   logic [15:0] cyc_count;
   logic [3:0]  cyc_count4;

   pc_sequencer #(.D(12), .CW(16)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
      .branch_en(branch_en), .taken(taken), .target(target),
      .prog_ctr(prog_ctr), .busy(busy), .done(done), .bad_target(bad_target),
      .cyc_count(cyc_count)
   );

   pc_sequencer #(.D(12), .CW(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
      .branch_en(branch_en), .taken(taken), .target(target),
      .prog_ctr(prog_ctr4), .busy(busy4), .done(done4), .bad_target(bad_target4),
      .cyc_count(cyc_count4)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      bit busy;
      bit done;
      bit bad;
      int cyc16;
      int cyc4;
   } exp_t;

   exp_t expq[$];
   int   nvec = 0;
   int   nmis = 0;

   // Reference model: mode 0 idle, 1 run, 2 done; n is the true RUN cycle count.
   int   m_mode = 0;
   int   m_pc   = 0;
   int   m_n    = 0;
   bit   m_bad  = 1'b0;

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_edge(input bit s, input bit st, input bit h, input bit be,
                             input bit tk, input int tg);
      if (reset) begin
         m_mode = 0; m_pc = 0; m_n = 0; m_bad = 1'b0;
      end else if (m_mode == 0 || m_mode == 2) begin
         if (s) begin
            m_mode = 1; m_pc = 0; m_n = 0; m_bad = 1'b0;
         end
      end else begin
         if (s) begin
            m_pc = 0; m_n = 0; m_bad = 1'b0;
         end else if (h) begin
            m_mode = 2; m_n = m_n + 1;
         end else if (st) begin
            m_n = m_n + 1;
         end else begin
            m_n = m_n + 1;
            if (be && tk && tg != 0) m_pc = tg;
            else begin
               m_pc = (m_pc + 1) % 4096;
               if (be && tk) m_bad = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input bit s, input bit st, input bit h, input bit be,
                       input bit tk, input int tg);
      exp_t e;
      @(negedge clk);
      start = s; stall = st; halt = h; branch_en = be; taken = tk; target = 12'(tg);
      model_edge(s, st, h, be, tk, tg);
      e.pc    = m_pc;
      e.busy  = (m_mode == 1);
      e.done  = (m_mode == 2);
      e.bad   = m_bad;
      e.cyc16 = min_i(m_n, 65535);
      e.cyc4  = min_i(m_n, 15);
      expq.push_back(e);
   endtask

   task automatic plain(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      start = 0; stall = 0; halt = 0; branch_en = 0; taken = 0; target = '0;
      reset = 1'b0;
   endtask

   // Monitor: outputs are presented every cycle; compare one expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            nvec++;
            if (int'(prog_ctr) != e.pc || busy != e.busy || done != e.done ||
                bad_target != e.bad || int'(cyc_count) != e.cyc16 ||
                int'(cyc_count4) != e.cyc4 || int'(prog_ctr4) != e.pc ||
                busy4 != e.busy || done4 != e.done || bad_target4 != e.bad) begin
               nmis++;
               $display("FAIL vec%0d t=%0t: got pc=%0d busy=%0b done=%0b bad=%0b cyc=%0d cyc4=%0d pc4=%0d, want pc=%0d busy=%0b done=%0b bad=%0b cyc=%0d cyc4=%0d",
                        nvec, $time, prog_ctr, busy, done, bad_target, cyc_count, cyc_count4,
                        prog_ctr4, e.pc, e.busy, e.done, e.bad, e.cyc16, e.cyc4);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      // Power-on reset
      step(0, 0, 0, 0, 0, 0);
      release_reset();
      // IDLE ignores everything except start
      step(0, 1, 1, 1, 1, 77);
      step(0, 0, 0, 1, 1, 0);

      // Straight-line run: 0..5 then halt, cyc 6
      step(1, 0, 0, 0, 0, 0);
      plain(5);
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 1, 9);
      step(0, 0, 0, 0, 0, 0);

      // Branch, not-taken branch, stall
      step(1, 0, 0, 0, 0, 0);
      plain(3);
      step(0, 0, 0, 1, 1, 48);
      step(0, 0, 0, 1, 0, 200);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 300);
      plain(1);
      step(0, 0, 1, 0, 0, 0);

      // Invalid target: sticky bad_target through DONE, cleared by start
      step(1, 0, 0, 0, 0, 0);
      plain(10);
      step(0, 0, 0, 1, 1, 0);
      plain(2);
      step(0, 0, 1, 0, 0, 0);
      plain(2);
      step(1, 0, 0, 0, 0, 0);

      // Halt beats a taken branch; start beats halt; wrap at 4095
      plain(4);
      step(0, 0, 1, 1, 1, 96);
      step(1, 0, 0, 0, 0, 0);
      plain(20);
      step(1, 1, 1, 1, 1, 55);
      step(0, 0, 0, 1, 1, 4095);
      plain(2);

      // Asynchronous reset mid-run at prog_ctr=37
      step(1, 0, 0, 0, 0, 0);
      plain(37);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      nvec++;
      if (prog_ctr != 0 || busy != 0 || done != 0 || bad_target != 0 || cyc_count != 0) begin
         nmis++;
         $display("FAIL async_reset: got pc=%0d busy=%0b done=%0b bad=%0b cyc=%0d, want all 0",
                  prog_ctr, busy, done, bad_target, cyc_count);
      end
      step(1, 0, 0, 0, 0, 0);
      release_reset();
      step(0, 0, 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit s, st, h, be, tk;
         int tg;
         s  = ($urandom_range(99) < 3);
         h  = ($urandom_range(99) < 4);
         st = ($urandom_range(99) < 20);
         be = ($urandom_range(99) < 30);
         tk = ($urandom_range(1) == 1);
         tg = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(4095));
         step(s, st, h, be, tk, tg);
      end

      wait_cyc = 0;
      while (expq.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      @(negedge clk);
      if (expq.size() > 0) begin
         nmis++;
         $display("FAIL drain: %0d expectations left, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter stage sitting directly downstream of the branch-target lookup table.
- Consumes the 12-bit absolute branch target and produces the instruction-fetch address each cycle.
- Sequences one program run per start request: idle -> run -> done, with stall, halt, and a cycle counter for the test harness.

Parameters:
D, 12, program counter width; matches the lookup table target width.
CW, 16, cycle counter width.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin (or restart) a program run; sampled on clock edge
stall  input  1  hold program counter this cycle (fetch/memory not ready)
halt  input  1  decoded halt instruction at current prog_ctr
branch_en  input  1  decoded instruction is a lookup-table branch
taken  input  1  branch condition true (from ALU flags)
target  input  D  absolute branch target from lookup table
prog_ctr  output  D  current instruction address
busy  output  1  high while in RUN
done  output  1  high while in DONE
bad_target  output  1  sticky flag: taken branch received target 0
cyc_count  output  CW  cycles spent in RUN for the current program

Behaviour:
- States: IDLE, RUN, DONE. State, prog_ctr and cyc_count are registered. busy and done decode the state directly.
- Reset: applied asynchronously, independent of clk. Values while reset is high:
  - state=IDLE, prog_ctr=0, busy=0, done=0, bad_target=0, cyc_count=0.
  - Reset mid-run aborts immediately; no partial update survives.
- IDLE:
  - prog_ctr held at 0.
  - start=1 -> RUN at the next edge, with prog_ctr=0, cyc_count=0, bad_target=0.
  - All other inputs are ignored.
- RUN: per-edge priority, highest first:
  1. start=1 -> restart: prog_ctr=0, cyc_count=0, bad_target=0, stay RUN.
  2. halt=1 -> DONE. prog_ctr holds the halt address. cyc_count increments once (the halt cycle counts).
  3. stall=1 -> prog_ctr holds, cyc_count increments. A branch presented during stall is ignored; decode re-presents it.
  4. branch_en=1 and taken=1:
     - target!=0 -> prog_ctr=target.
     - target==0 -> the lookup table's invalid-index default. prog_ctr=prog_ctr+1 and bad_target is set (sticky until start or reset).
  5. Otherwise -> prog_ctr=prog_ctr+1.
  - branch_en=1 with taken=0 is a plain increment.
- Arithmetic:
  - The increment is modulo 2^D: 2^D-1 wraps to 0 and no flag is raised.
  - cyc_count saturates at 2^CW-1 and does not wrap.
- DONE:
  - prog_ctr, cyc_count and bad_target hold.
  - start=1 -> RUN with the same initialisation as from IDLE.
  - stall, halt and branch inputs are ignored.
- Latency:
  - prog_ctr reflects a decision one edge after the inputs are sampled.
  - done rises the edge after halt is sampled in RUN.
- Simultaneous events:
  - halt and taken branch together -> halt wins; the PC is not redirected.
  - start and halt together -> restart wins.
- Inputs other than reset are assumed synchronous to clk.

Test Plan:
1. Reset: pulse reset asynchronously mid-cycle during RUN at prog_ctr=37 -> outputs go to prog_ctr=0, busy=0, done=0, cyc_count=0 without waiting for a clk edge. After release, state is IDLE.
2. Straight-line run: start pulse, 5 cycles with no branch, then halt -> prog_ctr sequence 0,1,2,3,4,5 held at 5. done=1 the edge after halt. cyc_count=6.
3. Branch and stall:
   - At prog_ctr=3, branch_en=1, taken=1, target=48 -> next prog_ctr=48.
   - taken=0 at 48 -> 49.
   - stall for 2 cycles at 49 -> holds 49 twice and cyc_count still advances.
4. Invalid target: taken branch with target=0 at prog_ctr=10 -> prog_ctr=11 and bad_target=1. bad_target stays 1 through halt and DONE, then clears on the next start.
5. Priority/wrap:
   - halt and taken branch (target=96) same cycle -> DONE at the current PC, no redirect.
   - start asserted in RUN at prog_ctr=20 -> prog_ctr=0, cyc_count=0.
   - Branch to target=4095 then increment -> prog_ctr=0.
6. Saturation: with CW=4, run 20 cycles without halt -> cyc_count stops at 15.
